// File: rtl/prod_bin2bcd_pkg.sv
// Shared types and constants for the signed product to BCD display stage.
// Default sizes match the 8x8 Booth multiplier upstream.
package prod_bin2bcd_pkg;

  localparam int PROD_N = 8;
  localparam int W      = 2 * PROD_N;

  localparam logic [3:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FINISH
  } bin2bcd_state_t;

endpackage

// File: rtl/prod_bin2bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
// The sum stays within 4 bits; there is no carry out of a digit.
module bcd_digit_adj
  import prod_bin2bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= ADD3_THRESH)
      q = d + 4'd3;
  end

endmodule

// File: rtl/prod_bin2bcd.sv
// Sequential signed-binary to BCD converter for the multiplier product.
// Converts the magnitude one bit per cycle; sign/bcd only change on completion.
module prod_bin2bcd
  import prod_bin2bcd_pkg::*;
#(
  parameter int N      = 8,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*N-1:0]        Y,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int WP = 2 * N;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WP + 1);

  bin2bcd_state_t state;

  logic [WP-1:0]    mag;
  logic             sgn;
  logic [BW-1:0]    scr;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt;
  logic [BW+WP-1:0] shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (scr[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  assign shifted = {adj, mag} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mag   <= '0;
      sgn   <= 1'b0;
      scr   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sign  <= 1'b0;
      bcd   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mag   <= Y[WP-1] ? (~Y + 1'b1) : Y;
            sgn   <= Y[WP-1];
            scr   <= '0;
            cnt   <= CW'(WP);
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          scr <= shifted[BW+WP-1:WP];
          mag <= shifted[WP-1:0];
          cnt <= cnt - 1'b1;
          // last shift: publish the whole result at once
          if (cnt == CW'(1)) begin
            bcd   <= shifted[BW+WP-1:WP];
            sign  <= sgn;
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_bin2bcd.sv
// Directed and random checks for prod_bin2bcd (N=8, DIGITS=5).
module tb_prod_bin2bcd;

  localparam int WB = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [WB-1:0]   y;
  logic            busy;
  logic            done;
  logic            sign;
  logic [19:0]     bcd;

  int n_vec = 0;
  int n_bad = 0;

  logic        prev_sign;
  logic [19:0] prev_bcd;

  typedef struct {
    logic [15:0] y;
    logic        s;
    logic [19:0] b;
  } vec_t;

  vec_t tbl[6];

  prod_bin2bcd #(.N(8), .DIGITS(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Y     (y),
    .busy  (busy),
    .done  (done),
    .sign  (sign),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic start_conv(input logic [WB-1:0] v);
    @(negedge clk);
    y     = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done; checks display hold.
  task automatic wait_done(output int lat, output bit stable);
    lat    = 0;
    stable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (bcd !== prev_bcd || sign !== prev_sign)
        stable = 1'b0;
    end
  endtask

  task automatic finish_checks(input string name, input int lat,
                               input bit st, input logic es,
                               input logic [19:0] eb);
    check({name, " latency"}, lat, 16);
    check({name, " sign"}, 32'(sign), 32'(es));
    check({name, " bcd"}, 32'(bcd), 32'(eb));
    check({name, " hold"}, 32'(st), 32'd1);
    @(posedge clk);
    #1;
    check({name, " busy_after"}, 32'(busy), 32'd0);
    check({name, " done_pulse"}, 32'(done), 32'd0);
    prev_bcd  = bcd;
    prev_sign = sign;
  endtask

  task automatic run(input string name, input logic [WB-1:0] v,
                     input logic es, input logic [19:0] eb);
    int lat;
    bit st;
    start_conv(v);
    wait_done(lat, st);
    finish_checks(name, lat, st, es, eb);
  endtask

  initial begin
    int lat;
    bit st;
    logic [15:0] ry;
    int          sv;
    int unsigned mg;

    tbl[0] = '{16'd0,     1'b0, 20'h00000};
    tbl[1] = '{16'd12345, 1'b0, 20'h12345};
    tbl[2] = '{16'h7FFF,  1'b0, 20'h32767};
    tbl[3] = '{16'hC080,  1'b1, 20'h16256};
    tbl[4] = '{16'h8000,  1'b1, 20'h32768};
    tbl[5] = '{16'hFFF9,  1'b1, 20'h00007};

    rst       = 1'b1;
    start     = 1'b0;
    y         = '0;
    prev_bcd  = '0;
    prev_sign = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sign", 32'(sign), 32'd0);
    check("reset bcd", 32'(bcd), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run($sformatf("vec%0d", i), tbl[i].y, tbl[i].s, tbl[i].b);

    // start while busy must be dropped, not queued
    start_conv(16'd42);
    repeat (4) @(negedge clk);
    check("busy during conv", 32'(busy), 32'd1);
    y     = 16'd99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    y     = 16'd12;
    wait_done(lat, st);
    lat = lat + 5;
    finish_checks("ignore", lat, st, 1'b0, 20'h00042);
    run("back2back", 16'd99, 1'b0, 20'h00099);

    // async reset in the middle of a conversion
    run("pre_rst", 16'd555, 1'b0, 20'h00555);
    start_conv(16'hFFFF);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst bcd", 32'(bcd), 32'd0);
    check("midrst sign", 32'(sign), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    prev_bcd  = '0;
    prev_sign = 1'b0;
    run("post_rst", 16'd1, 1'b0, 20'h00001);

    for (int i = 0; i < 1000; i++) begin
      ry = 16'($urandom);
      sv = int'(signed'(ry));
      mg = (sv < 0) ? int'(-sv) : sv;
      run($sformatf("rnd%0d y=%h", i, ry), ry, ry[15], to_bcd(mg));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
